// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, frame
// constants and the bit-period arithmetic derived from clock and baud rate.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Clocks from the start-bit edge to the middle of the start bit.
    function automatic int calc_half(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// a parameter so idle-high and idle-low lines can both use it.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the async input, then re-register it to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a valid/ready output register,
// a one-cycle frame-error pulse and a sticky overrun flag.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int HALF  = calc_half(DIV);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   armed;
    logic                   stop_seen;
    logic                   stop_ok;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != ST_IDLE);

    // Frame decoder FSM plus output register, handshake and error flags.
    // armed stays low for the first edge after reset release so that edge
    // performs no decoding. The stop-bit outcome is latched at the sample
    // edge and acted on one edge later, which is when the FSM leaves STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_prev   <= 1'b1;
            armed     <= 1'b0;
            stop_seen <= 1'b0;
            stop_ok   <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            rx_prev   <= rx_s;
            armed     <= 1'b1;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (armed) begin
                case (state)
                    ST_IDLE: begin
                        // Only a genuine high-to-low transition starts a frame.
                        if (rx_prev && !rx_s) begin
                            cnt   <= HALF_M1;
                            state <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (cnt == '0) begin
                            if (!rx_s) begin
                                cnt     <= DIV_M1;
                                bit_idx <= '0;
                                state   <= ST_DATA;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == '0) begin
                            shift <= {rx_s, shift[DATA_BITS-1:1]};
                            cnt   <= DIV_M1;
                            if (bit_idx == LAST_BIT) begin
                                state <= ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (stop_seen) begin
                            stop_seen <= 1'b0;
                            state     <= ST_IDLE;
                            if (stop_ok) begin
                                data  <= shift;
                                valid <= 1'b1;
                                if (valid && !ready) begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else if (cnt == '0) begin
                            stop_seen <= 1'b1;
                            stop_ok   <= rx_s;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 CLK_I  input  1  system clock; all logic rising-edge on this single clock.
REQ-004 RST_N_I  input  1  reset, asynchronous assert, active-low.
REQ-005 UART_RX_I  input  1  serial line, idle high, asynchronous to CLK_I.
REQ-006 DATA_O  output  8  received byte, LSB first on the line.
REQ-007 VALID_O  output  1  DATA_O holds an unconsumed byte.
REQ-008 READY_I  input  1  consumer accepts DATA_O when VALID_O and READY_I are high on the same edge.
REQ-009 FRAME_ERR_O  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 OVERRUN_O  output  1  sticky flag, byte completed while VALID_O already high.
REQ-011 BUSY_O  output  1  high in any state other than IDLE.

Function
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-013 Bit period DIV SHALL equal CLK_HZ/BAUD rounded to nearest integer (104 at defaults); HALF = DIV/2 (52).
REQ-014 UART_RX_I SHALL pass through a 2-flop synchronizer, reset to 1; all decoding uses the synchronized value.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE: on synchronized falling edge (1 then 0) load counter with HALF-1, go START.
REQ-017 START: at counter zero sample line; if 0 load DIV-1, bit index 0, go DATA; if 1 (glitch) return IDLE with no output.
REQ-018 DATA: at each counter zero shift sampled bit into shift register MSB, reload DIV-1; after bit index 7 go STOP.
REQ-019 STOP: at counter zero sample; 1 -> commit byte; 0 -> pulse FRAME_ERR_O for one cycle, discard byte; both return IDLE in the next cycle.
REQ-020 Commit: DATA_O <= shift register, VALID_O <= 1, one cycle after the stop-bit sample edge.
REQ-021 VALID_O SHALL stay high and DATA_O stable until handshake; VALID_O clears on the handshake edge.
REQ-022 Commit while VALID_O high and no handshake that edge: DATA_O overwritten with new byte, VALID_O stays 1, OVERRUN_O set.
REQ-023 Commit coincident with handshake: new byte loaded, VALID_O stays 1, no overrun.
REQ-024 OVERRUN_O SHALL clear only on reset.
REQ-025 Frame error from stop-bit low SHALL NOT re-arm start detection until line returns high (IDLE requires 1-then-0 edge).
REQ-026 Counter width SHALL be clog2(DIV) bits; no wrap beyond DIV-1.

Reset
REQ-027 RST_N_I low SHALL immediately force: state IDLE, counter 0, bit index 0, shift register 0x00, DATA_O 0x00, VALID_O 0, FRAME_ERR_O 0, OVERRUN_O 0, BUSY_O 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL abandon the frame; the first complete frame after release is received correctly.
REQ-029 Reset deassertion SHALL be consumed synchronously; the first edge after release performs no frame decoding.

Structure
REQ-030 State encoding, DIV/HALF computation and frame constants (8 data bits, 1 stop) SHALL live in the shared defs include.
REQ-031 Synchronizer SHALL be a sub-module sync2 (2-flop, reset value parameter) reusable by other CDC inputs.
REQ-032 No other sub-modules; a single FSM plus counters in uart_rx.

Verification
REQ-033 Defaults, send 0x55 at 115200 with READY_I=1 -> one VALID_O cycle, DATA_O=0x55, FRAME_ERR_O=0, OVERRUN_O=0.
REQ-034 READY_I=0, send 0xA3 then 0x3C -> after 2nd frame DATA_O=0x3C, VALID_O=1, OVERRUN_O=1.
REQ-035 Send 0xFF with stop bit forced low -> FRAME_ERR_O one-cycle pulse, VALID_O stays 0.
REQ-036 Low glitch of 20 clocks on idle line -> returns IDLE, no VALID_O, no FRAME_ERR_O.
REQ-037 Assert RST_N_I during data bit 4 of 0x81, release, send 0x7E -> only 0x7E delivered, all outputs reset values during reset.
REQ-038 Baud skew +2% and -2% sending 0x00 and 0xFF back-to-back -> both bytes received without error.
